// File: rtl/stream_layout_cvtor_pkg.sv
// Shared definitions for the stream layout converter: FSM encoding, mode values
// and the tile-size helper.
package stream_layout_cvtor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BYPASS = 3'd1,
    ST_RUN    = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic MODE_REORDER = 1'b0;
  localparam logic MODE_BYPASS  = 1'b1;

  // Words per tile; evaluated once per job when the configuration is captured.
  function automatic logic [11:0] tile_words(input logic [6:0] cols, input logic [4:0] chg);
    return 12'(cols) * 12'(chg);
  endfunction

endpackage

// File: rtl/stream_layout_cvtor_pingpong_ram.sv
// Two-bank tile buffer: one write port, one synchronous read port. The address
// MSB selects the bank; rdata holds its value while re is low.
module stream_layout_cvtor_pingpong_ram #(
  parameter int TBITS = 64,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW:0]      waddr,
  input  logic [TBITS-1:0] wdata,
  input  logic             re,
  input  logic [AW:0]      raddr,
  output logic [TBITS-1:0] rdata
);

  logic [TBITS-1:0] mem [2**(AW+1)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/stream_layout_cvtor.sv
// Reorders tiles from channel-group-major to column-major order through a
// ping-pong buffer, or passes the stream straight through in bypass mode.
module stream_layout_cvtor
  import stream_layout_cvtor_pkg::*;
#(
  parameter int TBITS    = 64,
  parameter int TBYTE    = 8,
  parameter int MAX_COLS = 64,
  parameter int MAX_CHG  = 16,
  parameter int AW       = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cfg_mode,
  input  logic [6:0]       cfg_cols,
  input  logic [4:0]       cfg_chg,
  input  logic [15:0]      cfg_tiles,
  input  logic [TBITS-1:0] din_isif_data,
  input  logic [TBYTE-1:0] din_isif_strb,
  input  logic             din_isif_last,
  input  logic             din_isif_empty_n,
  output logic             dout_isif_read,
  output logic [TBITS-1:0] dout_osif_data,
  output logic [TBYTE-1:0] dout_osif_strb,
  output logic             dout_osif_last,
  input  logic             din_osif_full_n,
  output logic             dout_osif_write,
  output logic             done,
  output logic             err_last,
  output logic [2:0]       current_state,
  output logic [1:0]       debug_bank_full,
  output logic [15:0]      debug_wr_cnt,
  output logic [15:0]      debug_rd_cnt
);

  if (2**AW < MAX_COLS * MAX_CHG) begin : g_aw_check
    $error("AW too small for MAX_COLS*MAX_CHG");
  end
  if (TBYTE * 8 != TBITS) begin : g_strb_check
    $error("TBYTE must equal TBITS/8");
  end

  state_t state, state_nxt;

  logic [6:0]    cols_q;
  logic [4:0]    chg_q;
  logic [15:0]   tiles_q;
  logic [AW-1:0] n_last;

  logic          wsel, rsel;
  logic [AW-1:0] waddr, raddr;
  logic [1:0]    bank_full, bank_set, bank_clr;
  logic [15:0]   wr_cnt, rd_cnt;
  logic [6:0]    rcol;
  logic [4:0]    rgrp;

  logic             s1_valid, s1_last;
  logic             oreg_valid, oreg_last;
  logic [TBITS-1:0] oreg_data, ram_rdata;

  logic job_start, run, drain;
  logic wr_read, wr_pop, wr_last, byp_pop;
  logic push, s1_move, rd_issue, rd_word_last, rd_tile_last;

  assign job_start = (state == ST_IDLE) && start;
  assign run       = (state == ST_RUN);
  assign drain     = (state == ST_RUN) || (state == ST_FLUSH);

  // Write engine: stop popping once the whole job has been captured.
  assign wr_last = (waddr == n_last);
  assign wr_read = run && din_isif_empty_n && !bank_full[wsel] && (wr_cnt != tiles_q);
  assign wr_pop  = wr_read;
  assign byp_pop = (state == ST_BYPASS) && din_isif_empty_n && din_osif_full_n;

  // Read pipeline: RAM output stage (s1) then output register. A read is issued
  // only if the word already in s1 can advance, so nothing is ever overwritten.
  assign push         = drain && oreg_valid && din_osif_full_n;
  assign s1_move      = s1_valid && (!oreg_valid || push);
  assign rd_issue     = drain && bank_full[rsel] && (!s1_valid || s1_move);
  assign rd_word_last = (rcol == cols_q - 7'd1) && (rgrp == chg_q - 5'd1);
  assign rd_tile_last = (rd_cnt == tiles_q - 16'd1);

  assign bank_set = (wr_pop && wr_last)        ? (2'b01 << wsel) : 2'b00;
  assign bank_clr = (rd_issue && rd_word_last) ? (2'b01 << rsel) : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = (cfg_mode == MODE_BYPASS) ? ST_BYPASS : ST_RUN;
      ST_BYPASS: if (byp_pop && din_isif_last) state_nxt = ST_DONE;
      ST_RUN:    if (wr_cnt == tiles_q) state_nxt = ST_FLUSH;
      ST_FLUSH:  if ((rd_cnt == tiles_q) && !s1_valid && !oreg_valid) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cols_q  <= '0;
      chg_q   <= '0;
      tiles_q <= '0;
      n_last  <= '0;
    end else if (job_start) begin
      cols_q  <= cfg_cols;
      chg_q   <= cfg_chg;
      tiles_q <= cfg_tiles;
      n_last  <= AW'(tile_words(cfg_cols, cfg_chg) - 12'd1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wsel   <= 1'b0;
      waddr  <= '0;
      wr_cnt <= '0;
    end else if (job_start) begin
      wsel   <= 1'b0;
      waddr  <= '0;
      wr_cnt <= '0;
    end else if (wr_pop) begin
      if (wr_last) begin
        waddr  <= '0;
        wsel   <= ~wsel;
        wr_cnt <= wr_cnt + 16'd1;
      end else begin
        waddr  <= waddr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                err_last <= 1'b0;
    else if (wr_pop && (din_isif_last != wr_last)) err_last <= 1'b1;
  end

  // Clear wins over set so a bank drained this cycle is writable next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          bank_full <= 2'b00;
    else if (job_start) bank_full <= 2'b00;
    else                bank_full <= (bank_full | bank_set) & ~bank_clr;
  end

  // raddr = grp*cols + col, stepped by +cols along a column.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsel   <= 1'b0;
      rcol   <= '0;
      rgrp   <= '0;
      raddr  <= '0;
      rd_cnt <= '0;
    end else if (job_start) begin
      rsel   <= 1'b0;
      rcol   <= '0;
      rgrp   <= '0;
      raddr  <= '0;
      rd_cnt <= '0;
    end else if (rd_issue) begin
      if (rd_word_last) begin
        rsel   <= ~rsel;
        rcol   <= '0;
        rgrp   <= '0;
        raddr  <= '0;
        rd_cnt <= rd_cnt + 16'd1;
      end else if (rgrp == chg_q - 5'd1) begin
        rgrp  <= '0;
        rcol  <= rcol + 7'd1;
        raddr <= AW'(rcol + 7'd1);
      end else begin
        rgrp  <= rgrp + 5'd1;
        raddr <= raddr + AW'(cols_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      oreg_valid <= 1'b0;
      oreg_last  <= 1'b0;
      oreg_data  <= '0;
    end else if (job_start) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      oreg_valid <= 1'b0;
      oreg_last  <= 1'b0;
    end else begin
      if (rd_issue) begin
        s1_valid <= 1'b1;
        s1_last  <= rd_word_last && rd_tile_last;
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end
      if (s1_move) begin
        oreg_valid <= 1'b1;
        oreg_data  <= ram_rdata;
        oreg_last  <= s1_last;
      end else if (push) begin
        oreg_valid <= 1'b0;
      end
    end
  end

  stream_layout_cvtor_pingpong_ram #(
    .TBITS(TBITS),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_pop),
    .waddr({wsel, waddr}),
    .wdata(din_isif_data),
    .re   (rd_issue),
    .raddr({rsel, raddr}),
    .rdata(ram_rdata)
  );

  always_comb begin
    dout_isif_read  = 1'b0;
    dout_osif_write = 1'b0;
    dout_osif_data  = '0;
    dout_osif_strb  = '0;
    dout_osif_last  = 1'b0;
    case (state)
      ST_BYPASS: begin
        dout_isif_read  = byp_pop;
        dout_osif_write = byp_pop;
        dout_osif_data  = din_isif_data;
        dout_osif_strb  = din_isif_strb;
        dout_osif_last  = din_isif_last;
      end
      ST_RUN, ST_FLUSH: begin
        dout_isif_read  = wr_read;
        dout_osif_write = push;
        dout_osif_data  = oreg_data;
        dout_osif_strb  = '1;
        dout_osif_last  = oreg_last;
      end
      default: ;
    endcase
  end

  assign done            = (state == ST_DONE);
  assign current_state   = state;
  assign debug_bank_full = bank_full;
  assign debug_wr_cnt    = wr_cnt;
  assign debug_rd_cnt    = rd_cnt;

endmodule

// File: tb/tb_stream_layout_cvtor.sv
// Randomized bench for stream_layout_cvtor: input FIFO model, output scoreboard
// fed by a queue-based tile reorder model, and directed corner scenarios.
module tb_stream_layout_cvtor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cfg_mode = 1'b0;
  logic [6:0]  cfg_cols = '0;
  logic [4:0]  cfg_chg = '0;
  logic [15:0] cfg_tiles = '0;
  logic [63:0] din_isif_data = '0;
  logic [7:0]  din_isif_strb = '0;
  logic        din_isif_last = 1'b0;
  logic        din_isif_empty_n = 1'b0;
  logic        dout_isif_read;
  logic [63:0] dout_osif_data;
  logic [7:0]  dout_osif_strb;
  logic        dout_osif_last;
  logic        din_osif_full_n = 1'b1;
  logic        dout_osif_write;
  logic        done;
  logic        err_last;
  logic [2:0]  current_state;
  logic [1:0]  debug_bank_full;
  logic [15:0] debug_wr_cnt;
  logic [15:0] debug_rd_cnt;

  stream_layout_cvtor dut (
    .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode),
    .cfg_cols(cfg_cols), .cfg_chg(cfg_chg), .cfg_tiles(cfg_tiles),
    .din_isif_data(din_isif_data), .din_isif_strb(din_isif_strb),
    .din_isif_last(din_isif_last), .din_isif_empty_n(din_isif_empty_n),
    .dout_isif_read(dout_isif_read), .dout_osif_data(dout_osif_data),
    .dout_osif_strb(dout_osif_strb), .dout_osif_last(dout_osif_last),
    .din_osif_full_n(din_osif_full_n), .dout_osif_write(dout_osif_write),
    .done(done), .err_last(err_last), .current_state(current_state),
    .debug_bank_full(debug_bank_full), .debug_wr_cnt(debug_wr_cnt),
    .debug_rd_cnt(debug_rd_cnt)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Entries are {strb[7:0], last, data[63:0]}
  logic [72:0] in_q[$];
  logic [72:0] exp_q[$];
  logic [72:0] exp_e;

  int n_checks = 0;
  int n_errors = 0;
  int fn_mode = 0;      // 0: full_n=1, 1: full_n=0, 2: random
  int pop_cnt = 0;
  int out_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  bit in_fire = 1'b0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Input FIFO and output-space driver: updates just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (in_fire && in_q.size() > 0) begin
        void'(in_q.pop_front());
        pop_cnt++;
      end
      din_isif_empty_n = (in_q.size() > 0);
      if (in_q.size() > 0) begin
        din_isif_strb = in_q[0][72:65];
        din_isif_last = in_q[0][64];
        din_isif_data = in_q[0][63:0];
      end else begin
        din_isif_strb = '0;
        din_isif_last = 1'b0;
        din_isif_data = '0;
      end
      case (fn_mode)
        0:       din_osif_full_n = 1'b1;
        1:       din_osif_full_n = 1'b0;
        default: din_osif_full_n = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor and scoreboard on the falling edge
  always @(negedge clk) begin
    cyc++;
    in_fire = dout_isif_read && din_isif_empty_n;
    if (done) done_cnt++;
    if (dout_osif_write) begin
      check("push_full_n", 80'(din_osif_full_n), 80'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_push", 80'd1, 80'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("out_word", 80'({dout_osif_strb, dout_osif_last, dout_osif_data}), 80'(exp_e));
      end
      if (out_cnt == 0) first_cyc = cyc;
      last_cyc = cyc;
      out_cnt++;
    end
  end

  // Reference model: tile t holds input word t*N + g*cols + c at (col c, group g);
  // output walks columns outermost, groups innermost.
  task automatic load_reorder(input int cols, input int chg, input int tiles, input bit seq);
    int n;
    logic [63:0] dw[$];
    logic [63:0] d;
    logic [7:0]  s;
    n = cols * chg;
    for (int t = 0; t < tiles; t++) begin
      for (int i = 0; i < n; i++) begin
        d = seq ? 64'(t * n + i) : {$urandom, $urandom};
        s = 8'($urandom);
        dw.push_back(d);
        in_q.push_back({s, (i == n - 1), d});
      end
    end
    for (int t = 0; t < tiles; t++)
      for (int c = 0; c < cols; c++)
        for (int g = 0; g < chg; g++)
          exp_q.push_back({8'hff, (t == tiles - 1 && c == cols - 1 && g == chg - 1),
                           dw[t * n + g * cols + c]});
  endtask

  task automatic do_start(input logic mode, input int cols, input int chg, input int tiles);
    @(posedge clk);
    #1;
    start = 1'b1;
    cfg_mode = mode;
    cfg_cols = 7'(cols);
    cfg_chg = 5'(chg);
    cfg_tiles = 16'(tiles);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 80'(done), 80'd1);
  endtask

  task automatic run_basic_reorder(input string tag);
    int d0;
    fn_mode = 0;
    out_cnt = 0;
    d0 = done_cnt;
    load_reorder(3, 2, 1, 1'b1);
    do_start(1'b0, 3, 2, 1);
    check({tag, "_state_run"}, 80'(current_state), 80'd2);
    wait_done(200);
    check({tag, "_state_done"}, 80'(current_state), 80'd4);
    @(negedge clk);
    check({tag, "_state_idle"}, 80'(current_state), 80'd0);
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, 80'(done_cnt - d0), 80'd1);
    check({tag, "_out_cnt"}, 80'(out_cnt), 80'd6);
    check({tag, "_exp_empty"}, 80'(exp_q.size()), 80'd0);
    check({tag, "_err_last"}, 80'(err_last), 80'd0);
    check({tag, "_wr_cnt"}, 80'(debug_wr_cnt), 80'd1);
    check({tag, "_rd_cnt"}, 80'(debug_rd_cnt), 80'd1);
  endtask

  initial begin
    int p0, n;
    logic [63:0] w;
    logic [7:0]  s;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_read", 80'(dout_isif_read), 80'd0);
    check("rst_write", 80'(dout_osif_write), 80'd0);
    check("rst_out", 80'({dout_osif_strb, dout_osif_last, dout_osif_data}), 80'd0);
    check("rst_done", 80'(done), 80'd0);
    check("rst_err", 80'(err_last), 80'd0);
    check("rst_state", 80'(current_state), 80'd0);
    check("rst_dbg", 80'({debug_bank_full, debug_wr_cnt, debug_rd_cnt}), 80'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic reorder 3x2: 0,3,1,4,2,5
    run_basic_reorder("reorder");

    // Bypass of 4 words
    fn_mode = 0;
    out_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      w = {$urandom, $urandom};
      s = 8'($urandom);
      in_q.push_back({s, (i == 3), w});
      exp_q.push_back({s, (i == 3), w});
    end
    repeat (2) @(negedge clk);
    do_start(1'b1, 1, 1, 1);
    check("byp_state", 80'(current_state), 80'd1);
    wait_done(50);
    check("byp_state_done", 80'(current_state), 80'd4);
    @(negedge clk);
    check("byp_state_idle", 80'(current_state), 80'd0);
    check("byp_out_cnt", 80'(out_cnt), 80'd4);
    check("byp_consecutive", 80'(last_cyc - first_cyc), 80'd3);
    check("byp_exp_empty", 80'(exp_q.size()), 80'd0);

    // Ping-pong stall with output blocked
    fn_mode = 1;
    out_cnt = 0;
    load_reorder(3, 2, 3, 1'b0);
    repeat (2) @(negedge clk);
    p0 = pop_cnt;
    do_start(1'b0, 3, 2, 3);
    repeat (60) @(negedge clk);
    check("stall_pops", 80'(pop_cnt - p0), 80'd12);
    check("stall_read", 80'(dout_isif_read), 80'd0);
    check("stall_banks", 80'(debug_bank_full), 80'd3);
    check("stall_no_out", 80'(out_cnt), 80'd0);
    do_start(1'b1, 1, 1, 1);
    check("start_ignored", 80'(current_state), 80'd2);
    fn_mode = 0;
    wait_done(300);
    repeat (2) @(negedge clk);
    check("stall_out_cnt", 80'(out_cnt), 80'd18);
    check("stall_exp_empty", 80'(exp_q.size()), 80'd0);

    // Random backpressure 4x4x4
    fn_mode = 2;
    out_cnt = 0;
    load_reorder(4, 4, 4, 1'b0);
    repeat (2) @(negedge clk);
    do_start(1'b0, 4, 4, 4);
    wait_done(2000);
    repeat (2) @(negedge clk);
    check("bp_out_cnt", 80'(out_cnt), 80'd64);
    check("bp_exp_empty", 80'(exp_q.size()), 80'd0);
    check("bp_err_last", 80'(err_last), 80'd0);

    // Early TLAST on the 3rd word
    fn_mode = 0;
    out_cnt = 0;
    load_reorder(2, 2, 1, 1'b1);
    n = in_q.size();
    in_q[n - 2][64] = 1'b1;
    in_q[n - 1][64] = 1'b0;
    repeat (2) @(negedge clk);
    do_start(1'b0, 2, 2, 1);
    wait_done(200);
    repeat (4) @(negedge clk);
    check("early_err_last", 80'(err_last), 80'd1);
    check("early_out_cnt", 80'(out_cnt), 80'd4);
    check("early_exp_empty", 80'(exp_q.size()), 80'd0);

    // Reset in the middle of a job
    fn_mode = 1;
    load_reorder(4, 4, 2, 1'b0);
    repeat (2) @(negedge clk);
    p0 = pop_cnt;
    do_start(1'b0, 4, 4, 2);
    n = 0;
    while (pop_cnt - p0 < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_pops_reached", 80'(pop_cnt - p0 >= 5), 80'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_state", 80'(current_state), 80'd0);
    check("mid_rst_io", 80'({dout_isif_read, dout_osif_write, done, err_last}), 80'd0);
    check("mid_rst_out", 80'({dout_osif_strb, dout_osif_last, dout_osif_data}), 80'd0);
    check("mid_rst_dbg", 80'({debug_bank_full, debug_wr_cnt, debug_rd_cnt}), 80'd0);
    in_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_basic_reorder("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
